// File: rtl/timer_pkg.sv
// Shared types and helpers for countdown_timer and its tick prescaler.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int MIN_PRESC_WIDTH = 1;

  // Prescaler counter width; a lone bit is still needed when PRESCALE<=2.
  function automatic int presc_width(input int prescale);
    return (prescale > 2) ? $clog2(prescale) : MIN_PRESC_WIDTH;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by PRESCALE while enabled; tick is high on the last cycle of each period.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int PRESCALE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int WIDTH = presc_width(PRESCALE);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/pause, prescaled decrement and a one-cycle done pulse.
// Optional build macro COUNTDOWN_AUTO_RELOAD_EN: expiry reloads the count and keeps running.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic                  start,
  input  logic                  pause,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  running,
  output logic                  paused,
  output logic                  done
);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] count_next;
  logic                  done_next;
  logic                  presc_en;
  logic                  tick;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [DATA_WIDTH-1:0] reload_q;
`endif

  // A coincident pause or load freezes the prescaler, so pause beats a tick.
  assign presc_en = (state == RUN) && !load && !pause;

  generate
    if (PRESCALE == 1) begin : g_no_presc
      assign tick = presc_en;
    end else begin : g_presc
      tick_prescaler #(
        .PRESCALE(PRESCALE)
      ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(presc_en),
        .clear (load),
        .tick  (tick)
      );
    end
  endgenerate

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    count_next = count;
    done_next  = 1'b0;
    if (load) begin
      state_next = IDLE;
      count_next = load_value;
    end else begin
      case (state)
        IDLE: begin
          if (!pause && start) begin
            if (count != '0) state_next = RUN;
            else             done_next  = 1'b1;
          end
        end
        RUN: begin
          if (pause) begin
            state_next = PAUSE;
          end else if (tick) begin
            if (count < DATA_WIDTH'(2)) begin
              done_next = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              count_next = reload_q;
              if (reload_q == '0) state_next = IDLE;
`else
              count_next = '0;
              state_next = IDLE;
`endif
            end else begin
              count_next = count - 1'b1;
            end
          end
        end
        PAUSE: begin
          if (!pause && start) state_next = RUN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      done  <= done_next;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    reload_q <= '0;
    else if (load) reload_q <= load_value;
  end
`endif

  assign running = (state == RUN);
  assign paused  = (state == PAUSE);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: two timers (PRESCALE 1 and 4) on shared stimulus, table vectors,
// hand sequences for multi-cycle corners and random stimulus against a behavioural model.
`timescale 1ns/1ps
module tb_countdown_timer;

  localparam int DW = 8;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [DW-1:0] load_value = '0;

  logic [DW-1:0] count_a, count_b;
  logic          running_a, paused_a, done_a;
  logic          running_b, paused_b, done_b;

  always #5 clk = ~clk;

  countdown_timer #(.DATA_WIDTH(DW), .PRESCALE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(count_a), .running(running_a),
    .paused(paused_a), .done(done_a));

  countdown_timer #(.DATA_WIDTH(DW), .PRESCALE(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(count_b), .running(running_b),
    .paused(paused_b), .done(done_b));

  int checks = 0;
  int errors = 0;

  // Behavioural model: remaining count, mode, cycles accumulated toward the next decrement.
  int presc[2] = '{1, 4};
  int m_cnt[2], m_rel[2], m_acc[2], m_mode[2];
  bit m_done[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic [DW-1:0] c, input logic r,
                                       input logic p, input logic d);
    return {21'b0, c, r, p, d};
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_rel[k] = 0; m_acc[k] = 0; m_mode[k] = M_IDLE; m_done[k] = 1'b0;
    end
  endfunction

  function automatic void model_step(input int k);
    m_done[k] = 1'b0;
    if (load) begin
      m_cnt[k] = int'(load_value); m_rel[k] = m_cnt[k]; m_acc[k] = 0; m_mode[k] = M_IDLE;
    end else if (m_mode[k] == M_IDLE) begin
      if (start && !pause) begin
        if (m_cnt[k] > 0) m_mode[k] = M_RUN;
        else              m_done[k] = 1'b1;
      end
    end else if (m_mode[k] == M_PAUSE) begin
      if (start && !pause) m_mode[k] = M_RUN;
    end else if (pause) begin
      m_mode[k] = M_PAUSE;
    end else begin
      m_acc[k]++;
      if (m_acc[k] == presc[k]) begin
        m_acc[k] = 0;
        m_cnt[k]--;
        if (m_cnt[k] == 0) begin
          m_done[k] = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          m_cnt[k] = m_rel[k];
          if (m_rel[k] == 0) m_mode[k] = M_IDLE;
`else
          m_mode[k] = M_IDLE;
`endif
        end
      end
    end
  endfunction

  function automatic logic [31:0] model_out(input int k);
    return pack(DW'(m_cnt[k]), m_mode[k] == M_RUN, m_mode[k] == M_PAUSE, m_done[k]);
  endfunction

  // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
  task automatic step(input bit ld, input logic [DW-1:0] lv, input bit st, input bit ps);
    load = ld; load_value = lv; start = st; pause = ps;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check("model_p1", pack(count_a, running_a, paused_a, done_a), model_out(0));
    check("model_p4", pack(count_b, running_b, paused_b, done_b), model_out(1));
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit            ld;
    logic [DW-1:0] lv;
    bit            st;
    bit            ps;
    logic [DW-1:0] cnt;
    bit            run;
    bit            pau;
    bit            dn;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n, first_done, dn;

    model_reset();
    #3;
    check("reset_a", pack(count_a, running_a, paused_a, done_a), 32'h0);
    check("reset_b", pack(count_b, running_b, paused_b, done_b), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table vectors, expectations for the PRESCALE=1 timer ----
    vecs.push_back('{1, 8'd5, 0, 0, 8'd5, 0, 0, 0});
    vecs.push_back('{0, 8'd0, 1, 0, 8'd5, 1, 0, 0});
    vecs.push_back('{0, 8'd0, 1, 0, 8'd4, 1, 0, 0});
    vecs.push_back('{0, 8'd0, 0, 0, 8'd3, 1, 0, 0});
    vecs.push_back('{0, 8'd0, 0, 0, 8'd2, 1, 0, 0});
    vecs.push_back('{0, 8'd0, 0, 0, 8'd1, 1, 0, 0});
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    vecs.push_back('{0, 8'd0, 0, 0, 8'd5, 1, 0, 1});
    vecs.push_back('{0, 8'd0, 0, 0, 8'd4, 1, 0, 0});
`else
    vecs.push_back('{0, 8'd0, 0, 0, 8'd0, 0, 0, 1});
    vecs.push_back('{0, 8'd0, 0, 0, 8'd0, 0, 0, 0});
`endif
    vecs.push_back('{1, 8'd0, 0, 0, 8'd0, 0, 0, 0});
    vecs.push_back('{0, 8'd0, 1, 0, 8'd0, 0, 0, 1});
    vecs.push_back('{0, 8'd0, 0, 0, 8'd0, 0, 0, 0});
    vecs.push_back('{1, 8'd4, 0, 0, 8'd4, 0, 0, 0});
    vecs.push_back('{0, 8'd0, 0, 1, 8'd4, 0, 0, 0});
    vecs.push_back('{0, 8'd0, 1, 0, 8'd4, 1, 0, 0});
    vecs.push_back('{0, 8'd0, 0, 1, 8'd4, 0, 1, 0});
    vecs.push_back('{0, 8'd0, 1, 1, 8'd4, 0, 1, 0});
    vecs.push_back('{0, 8'd0, 1, 0, 8'd4, 1, 0, 0});
    vecs.push_back('{0, 8'd0, 0, 0, 8'd3, 1, 0, 0});
    vecs.push_back('{1, 8'd9, 0, 0, 8'd9, 0, 0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].ps);
      check($sformatf("vec%0d", i), pack(count_a, running_a, paused_a, done_a),
            pack(vecs[i].cnt, vecs[i].run, vecs[i].pau, vecs[i].dn));
    end

    // ---- PRESCALE=4: load 3, done 13 cycles after start ----
    step(1'b1, 8'd3, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    first_done = -1;
    for (int c = 2; c <= 30; c++) begin
      idle();
      if (done_b && first_done < 0) first_done = c;
      if (c == 4) check("p4_hold", 32'(count_b), 32'd3);
      if (c == 5) check("p4_tick1", 32'(count_b), 32'd2);
      if (c == 9) check("p4_tick2", 32'(count_b), 32'd1);
    end
    check("p4_done_latency", 32'(first_done), 32'd13);

    // ---- pause at count 3 for 10 cycles, then resume ----
    step(1'b1, 8'd6, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    n = 0;
    while (count_a != 8'd3 && n < 20) begin
      idle();
      n++;
    end
    check("pause_reach3", 32'(count_a), 32'd3);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, i == 5, 1'b1);
      check("pause_hold", pack(count_a, running_a, paused_a, done_a), pack(8'd3, 0, 1, 0));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    dn = int'(done_a);
    for (int i = 0; i < 4; i++) begin
      idle();
      dn += int'(done_a);
    end
    check("pause_resume_done_once", 32'(dn), 32'd1);

    // ---- reload mid-run, restart, then async reset mid-run ----
    step(1'b1, 8'd8, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    n = 0;
    while (count_a != 8'd5 && n < 20) begin
      idle();
      n++;
    end
    step(1'b1, 8'd2, 1'b0, 1'b0);
    check("midload", pack(count_a, running_a, paused_a, done_a), pack(8'd2, 0, 0, 0));
    step(1'b0, '0, 1'b1, 1'b0);
    first_done = -1;
    for (int c = 2; c <= 10; c++) begin
      idle();
      if (done_a && first_done < 0) first_done = c;
    end
    check("midload_expiry", 32'(first_done), 32'd3);

    step(1'b1, 8'd8, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle();
    idle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_a", pack(count_a, running_a, paused_a, done_a), 32'h0);
    check("async_rst_b", pack(count_b, running_b, paused_b, done_b), 32'h0);
    @(negedge clk);
    check("rst_no_done", {30'b0, done_a, done_b}, 32'h0);
    rst_n = 1'b1;
    idle();

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // ---- auto-reload: three expiries every 3 cycles, running stays high ----
    step(1'b1, 8'd3, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    dn = int'(done_a);
    for (int i = 0; i < 9; i++) begin
      idle();
      dn += int'(done_a);
      check("auto_running", 32'(running_a), 32'd1);
    end
    check("auto_done_count", 32'(dn), 32'd3);
`endif

    // ---- random stimulus against the model ----
    for (int i = 0; i < 3000; i++) begin
      bit ld, st, ps;
      logic [DW-1:0] lv;
      ld = ($urandom_range(0, 15) == 0);
      lv = DW'($urandom_range(0, 12));
      ps = ($urandom_range(0, 7) == 0);
      st = !ps && ($urandom_range(0, 3) == 0);
      step(ld, lv, st, ps);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
